// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: conditions the pins, frames bytes and tracks
// the held state of the six game keys as level outputs.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate,
  output logic       raw_drop,
  output logic       raw_hold,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int FLT_W = $clog2(FILTER_LEN) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the nine data+parity bits contain an odd count of ones.
  function automatic logic odd_ones(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic             clk_s1_r, clk_s2_r, dat_s1_r, dat_s2_r;
  logic             filt_r, filt_d_r, fall_r;
  logic [FLT_W-1:0] flt_cnt_r;
  state_t           state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             parity_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             ext_r, brk_r;
  logic             raw_left_r, raw_right_r, raw_down_r, raw_rotate_r, raw_drop_r, raw_hold_r;
  logic             scan_valid_r, frame_err_r;
  logic [7:0]       scan_code_r;

  // Two-flop synchronizers for both pins, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_r <= 1'b1;
      clk_s2_r <= 1'b1;
      dat_s1_r <= 1'b1;
      dat_s2_r <= 1'b1;
    end else begin
      clk_s1_r <= ps2_clk;
      clk_s2_r <= clk_s1_r;
      dat_s1_r <= ps2_data;
      dat_s2_r <= dat_s1_r;
    end
  end

  // Clock glitch filter and registered falling-edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r    <= 1'b1;
      filt_d_r  <= 1'b1;
      fall_r    <= 1'b0;
      flt_cnt_r <= '0;
    end else begin
      filt_d_r <= filt_r;
      fall_r   <= filt_d_r & ~filt_r;
      if (clk_s2_r == filt_r) begin
        flt_cnt_r <= '0;
      end else if (flt_cnt_r == FLT_LAST) begin
        filt_r    <= clk_s2_r;
        flt_cnt_r <= '0;
      end else begin
        flt_cnt_r <= flt_cnt_r + FLT_W'(1);
      end
    end
  end

  // Frame receiver, timeout watchdog and make/break decoder with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      to_cnt_r     <= '0;
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      raw_left_r   <= 1'b0;
      raw_right_r  <= 1'b0;
      raw_down_r   <= 1'b0;
      raw_rotate_r <= 1'b0;
      raw_drop_r   <= 1'b0;
      raw_hold_r   <= 1'b0;
      scan_valid_r <= 1'b0;
      scan_code_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      scan_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (state_r == S_IDLE) begin
        to_cnt_r <= '0;
        if (fall_r && !dat_s2_r) begin
          state_r   <= S_DATA;
          bit_cnt_r <= 3'd0;
        end
      end else if (fall_r) begin
        to_cnt_r <= '0;
        case (state_r)
          S_DATA: begin
            shift_r   <= {dat_s2_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= S_PARITY;
            end
          end
          S_PARITY: begin
            parity_r <= dat_s2_r;
            state_r  <= S_STOP;
          end
          S_STOP: begin
            state_r <= S_IDLE;
            if (dat_s2_r && odd_ones({parity_r, shift_r})) begin
              scan_valid_r <= 1'b1;
              scan_code_r  <= shift_r;
              if (shift_r == 8'hE0) begin
                ext_r <= 1'b1;
              end else if (shift_r == 8'hF0) begin
                brk_r <= 1'b1;
              end else begin
                // Arrow keys need the E0 prefix; Space and C must not have it.
                case ({ext_r, shift_r})
                  9'h16B:  raw_left_r   <= ~brk_r;
                  9'h174:  raw_right_r  <= ~brk_r;
                  9'h172:  raw_down_r   <= ~brk_r;
                  9'h175:  raw_rotate_r <= ~brk_r;
                  9'h029:  raw_drop_r   <= ~brk_r;
                  9'h021:  raw_hold_r   <= ~brk_r;
                  default: ;
                endcase
                ext_r <= 1'b0;
                brk_r <= 1'b0;
              end
            end else begin
              frame_err_r <= 1'b1;
              ext_r       <= 1'b0;
              brk_r       <= 1'b0;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end else if (to_cnt_r == TO_LAST) begin
        state_r     <= S_IDLE;
        frame_err_r <= 1'b1;
        ext_r       <= 1'b0;
        brk_r       <= 1'b0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  assign raw_left   = raw_left_r;
  assign raw_right  = raw_right_r;
  assign raw_down   = raw_down_r;
  assign raw_rotate = raw_rotate_r;
  assign raw_drop   = raw_drop_r;
  assign raw_hold   = raw_hold_r;
  assign scan_valid = scan_valid_r;
  assign scan_code  = scan_code_r;
  assign frame_err  = frame_err_r;

endmodule
